// File: rtl/fp16_conv_arbiter_pkg.sv
// Shared fp16 field constants and the fp16 magnitude to uint16 conversion
// used by the conversion arbiter datapath.
package fp16_conv_arbiter_pkg;

    localparam int unsigned FP16_W       = 16;
    localparam int unsigned FP16_EXP_W   = 5;
    localparam int unsigned FP16_MANT_W  = 10;
    localparam int unsigned FP16_BIAS    = 15;
    localparam int unsigned FP16_EXP_MAX = 31;

    // Magnitude only; zero, subnormal, inf, NaN and values below 1.0 map to 0
    function automatic logic [FP16_W-1:0] fp16_to_u16(input logic [FP16_W-1:0] x);
        logic [FP16_EXP_W-1:0]  e;
        logic [FP16_MANT_W-1:0] m;
        logic [FP16_EXP_W-1:0]  k;
        logic [FP16_W-1:0]      v;
        logic [FP16_W-1:0]      r;
        e = x[FP16_W-2 -: FP16_EXP_W];
        m = x[FP16_MANT_W-1:0];
        v = FP16_W'({1'b1, m});
        k = e - FP16_EXP_W'(FP16_BIAS);
        if (e == '0 || e == FP16_EXP_W'(FP16_EXP_MAX) || e < FP16_EXP_W'(FP16_BIAS)) begin
            r = '0;
        end else if (k <= FP16_EXP_W'(FP16_MANT_W)) begin
            r = v >> (FP16_EXP_W'(FP16_MANT_W) - k);
        end else begin
            r = v << (k - FP16_EXP_W'(FP16_MANT_W));
        end
        return r;
    endfunction

endpackage

// File: rtl/fp16_conv_arbiter_if.sv
// Request/response bundle between fp16 requesters, the shared converter and
// the integer consumer.
interface fp16_conv_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [16*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic [ID_W-1:0]     resp_id;
    logic [15:0]         resp_data;
    logic                resp_ready;
    logic                busy;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/fp16_conv_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches cyclically from the last granted index + 1
// and moves its pointer only when the caller reports a completed transfer.
module fp16_conv_arbiter_rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             enable,
    input  logic             update,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= IDX_W'(N - 1);
        end else if (update) begin
            last <= grant_idx;
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IDX_W'((32'(last) + off) % N);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fp16_conv_arbiter.sv
// Shares one fp16->uint16 converter among N_REQ requesters through a
// round-robin grant and a two-stage pipeline with a single tagged response.
module fp16_conv_arbiter
    import fp16_conv_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input logic               clk,
    input logic               rst,
    fp16_conv_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic              adv;
    logic              xfer;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [FP16_W-1:0] sel_data;

    logic              s0_valid;
    logic [ID_W-1:0]   s0_id;
    logic [FP16_W-1:0] s0_data;
    logic              s1_valid;
    logic [ID_W-1:0]   s1_id;
    logic [FP16_W-1:0] s1_data;
    logic              busy_q;

    // Both stages move together whenever the output slot is free or draining
    assign adv  = ~s1_valid | bus.resp_ready;
    assign xfer = |(bus.req_valid & bus.req_ready);

    fp16_conv_arbiter_rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .enable    (adv & rst),
        .update    (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A lone requester sees the raw pipeline advance, independent of its valid
    if (N_REQ == 1) begin : g_single
        assign bus.req_ready = adv & rst;
    end else begin : g_multi
        assign bus.req_ready = grant;
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_data = bus.req_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_id    <= '0;
            s0_data  <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_data  <= '0;
            busy_q   <= 1'b0;
        end else if (adv) begin
            s0_valid <= xfer;
            s1_valid <= s0_valid;
            busy_q   <= xfer | s0_valid;
            if (xfer) begin
                s0_id   <= ID_W'(grant_idx);
                s0_data <= sel_data;
            end
            if (s0_valid) begin
                s1_id   <= s0_id;
                s1_data <= fp16_to_u16(s0_data);
            end
        end
    end

    assign bus.resp_valid = s1_valid;
    assign bus.resp_id    = s1_id;
    assign bus.resp_data  = s1_data;
    assign bus.busy       = busy_q;

endmodule
